// File: rtl/ir_key_pkg.sv
// Shared types and default constants for the IR key mapper.
package ir_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_LOCK  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] DIFF_MIN = 2'd1;
  localparam logic [1:0] DIFF_MAX = 2'd3;
  localparam int         NUM_DIFF = int'(DIFF_MAX);

  localparam int                   DEF_NUM_KEYS    = 7;
  localparam logic [7*8-1:0]       DEF_KEY_CODES   = {8'h40, 8'h4a, 8'h42, 8'h43, 8'h44, 8'h15, 8'h46};
  localparam logic [6:0]           DEF_TOGGLE_MASK = 7'b0001111;
  localparam logic [NUM_DIFF*8-1:0] DEF_DIFF_CODES = {8'h0d, 8'h19, 8'h16};

  // Index width that stays legal for a single-entry table.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ir_code_match.sv
// Combinational code-table lookup: key table first, then difficulty table.
// The lowest matching index wins in each table.
module ir_code_match
  import ir_key_pkg::*;
#(
  parameter int                      NUM_KEYS   = DEF_NUM_KEYS,
  parameter logic [NUM_KEYS*8-1:0]   KEY_CODES  = DEF_KEY_CODES,
  parameter logic [NUM_DIFF*8-1:0]   DIFF_CODES = DEF_DIFF_CODES,
  parameter int                      IDX_W      = idx_width(NUM_KEYS)
) (
  input  logic [7:0]       code,
  output logic             key_hit,
  output logic [IDX_W-1:0] key_idx,
  output logic             diff_hit,
  output logic [1:0]       diff_val
);

  // Key table scan from the top down so the lowest index overrides.
  always_comb begin
    key_hit = 1'b0;
    key_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[i*8 +: 8] == code) begin
        key_hit = 1'b1;
        key_idx = IDX_W'(i);
      end
    end
  end

  // Difficulty table scan; entry j selects difficulty j+1.
  always_comb begin
    diff_hit = 1'b0;
    diff_val = DIFF_MIN;
    for (int j = NUM_DIFF - 1; j >= 0; j--) begin
      if (DIFF_CODES[j*8 +: 8] == code) begin
        diff_hit = 1'b1;
        diff_val = 2'(j + 1);
      end
    end
  end

endmodule

// File: rtl/ir_key_mapper.sv
// IR key mapper: NEC command bytes -> one-hot key pulses, toggle levels, difficulty.
// Optional auto-repeat on NEC repeat frames when IR_KEY_AUTO_REPEAT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a frame strobe
//   PULSE | driving key_pulse for PULSE_CYCLES cycles
//   LOCK  | difficulty load or toggle-off lockout, no pulse
//   HOLD  | auto-repeat only: key held, counting repeat frames
module ir_key_mapper
  import ir_key_pkg::*;
#(
  parameter int                    NUM_KEYS     = DEF_NUM_KEYS,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES    = DEF_KEY_CODES,
  parameter logic [NUM_KEYS-1:0]   TOGGLE_MASK  = DEF_TOGGLE_MASK,
  parameter logic [NUM_DIFF*8-1:0] DIFF_CODES   = DEF_DIFF_CODES,
  parameter int                    PULSE_CYCLES = 5000,
  parameter int                    RPT_SKIP     = 2,
  parameter int                    RPT_TIMEOUT  = 600000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [7:0]          ir_code,
  input  logic                ir_vld,
  input  logic                ir_rpt,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic [1:0]          diff,
  output logic                busy
);

  localparam int               IDX_W    = idx_width(NUM_KEYS);
  localparam int               CNT_W    = $clog2(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [NUM_KEYS-1:0] pulse_nx, hold_nx;
  logic [1:0]          diff_nx;
  logic                key_hit, diff_hit;
  logic [IDX_W-1:0]    key_idx;
  logic [1:0]          diff_val;

`ifdef IR_KEY_AUTO_REPEAT_EN
  localparam int               RPT_W    = idx_width(RPT_SKIP + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_SKIP);
  localparam int               TMO_W    = idx_width(RPT_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RPT_TIMEOUT - 1);

  logic [IDX_W-1:0] hold_idx, idx_nx;
  logic [RPT_W-1:0] rpt_cnt, rpt_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_nx;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{ir_rpt, RPT_SKIP, RPT_TIMEOUT};
`endif

  ir_code_match #(
    .NUM_KEYS   (NUM_KEYS),
    .KEY_CODES  (KEY_CODES),
    .DIFF_CODES (DIFF_CODES),
    .IDX_W      (IDX_W)
  ) u_match (
    .code     (ir_code),
    .key_hit  (key_hit),
    .key_idx  (key_idx),
    .diff_hit (diff_hit),
    .diff_val (diff_val)
  );

  // Next-state and next-output logic; a new frame is only taken while idle (or holding).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pulse_nx = key_pulse;
    hold_nx  = key_hold;
    diff_nx  = diff;
`ifdef IR_KEY_AUTO_REPEAT_EN
    idx_nx   = hold_idx;
    rpt_nx   = rpt_cnt;
    tmo_nx   = tmo_cnt;
`endif
    case (state)
      ST_PULSE: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          pulse_nx = '0;
          state_nx = ST_IDLE;
`ifdef IR_KEY_AUTO_REPEAT_EN
          if (!TOGGLE_MASK[hold_idx]) begin
            state_nx = ST_HOLD;
            tmo_nx   = TMO_LAST;
          end
`endif
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
`ifdef IR_KEY_AUTO_REPEAT_EN
      ST_HOLD: begin
        if (ir_rpt) begin
          tmo_nx = TMO_LAST;
          if (rpt_cnt == RPT_LAST) begin
            state_nx = ST_PULSE;
            cnt_nx   = '0;
            pulse_nx = NUM_KEYS'(1) << hold_idx;
          end else begin
            rpt_nx = rpt_cnt + RPT_W'(1);
          end
        end else if (tmo_cnt == '0) begin
          state_nx = ST_IDLE;
        end else begin
          tmo_nx = tmo_cnt - TMO_W'(1);
        end
      end
`endif
      default: ;
    endcase

    // ir_vld takes priority over a coincident ir_rpt in HOLD.
    if (ir_vld && (state == ST_IDLE || state == ST_HOLD)) begin
      if (key_hit) begin
        cnt_nx = '0;
`ifdef IR_KEY_AUTO_REPEAT_EN
        idx_nx = key_idx;
        rpt_nx = '0;
`endif
        if (TOGGLE_MASK[key_idx] && key_hold[key_idx]) begin
          hold_nx  = '0;
          pulse_nx = '0;
          state_nx = ST_LOCK;
        end else begin
          if (TOGGLE_MASK[key_idx]) hold_nx = NUM_KEYS'(1) << key_idx;
          pulse_nx = NUM_KEYS'(1) << key_idx;
          state_nx = ST_PULSE;
        end
      end else if (diff_hit) begin
        diff_nx  = diff_val;
        pulse_nx = '0;
        cnt_nx   = '0;
        state_nx = ST_LOCK;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_pulse <= '0;
      key_hold  <= '0;
      diff      <= DIFF_MIN;
`ifdef IR_KEY_AUTO_REPEAT_EN
      hold_idx  <= '0;
      rpt_cnt   <= '0;
      tmo_cnt   <= '0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      key_pulse <= pulse_nx;
      key_hold  <= hold_nx;
      diff      <= diff_nx;
`ifdef IR_KEY_AUTO_REPEAT_EN
      hold_idx  <= idx_nx;
      rpt_cnt   <= rpt_nx;
      tmo_cnt   <= tmo_nx;
`endif
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ir_key_mapper.sv
// Testbench for ir_key_mapper: directed scenarios plus randomized frames
// checked against a time-based reference model.
module tb_ir_key_mapper;

  localparam int NK = 7;
  localparam int PC = 5000;
  localparam int RT = 300;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [7:0]    ir_code = 8'h00;
  logic          ir_vld  = 1'b0;
  logic          ir_rpt  = 1'b0;
  logic [NK-1:0] key_pulse, key_hold;
  logic [1:0]    diff;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  ir_key_mapper #(
    .PULSE_CYCLES (PC),
    .RPT_TIMEOUT  (RT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .ir_code   (ir_code),
    .ir_vld    (ir_vld),
    .ir_rpt    (ir_rpt),
    .key_pulse (key_pulse),
    .key_hold  (key_hold),
    .diff      (diff),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Code tables in key-index order; toggle keys are indices 0..3.
  logic [7:0]    key_tab  [NK] = '{8'h46, 8'h15, 8'h44, 8'h43, 8'h42, 8'h4a, 8'h40};
  logic [7:0]    diff_tab [3]  = '{8'h16, 8'h19, 8'h0d};
  logic [NK-1:0] tog           = 7'b0001111;

  // Reference model: remaining busy cycles, pulsing key, held toggle key, difficulty.
  int m_left = 0;
  int m_key  = -1;
  int m_hold = -1;
  int m_diff = 1;

  function automatic int find_key(logic [7:0] c);
    for (int i = 0; i < NK; i++) if (key_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic int find_diff(logic [7:0] c);
    for (int i = 0; i < 3; i++) if (diff_tab[i] == c) return i + 1;
    return 0;
  endfunction

  // Model update on each clock edge.
  always @(posedge sys_clk) begin
    int k;
    int d;
    if (sys_rst) begin
      m_left = 0; m_key = -1; m_hold = -1; m_diff = 1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_key = -1;
    end else if (ir_vld) begin
      k = find_key(ir_code);
      d = find_diff(ir_code);
      if (k >= 0) begin
        m_left = PC;
        if (tog[k] && m_hold == k) begin
          m_hold = -1;
          m_key  = -1;
        end else begin
          if (tog[k]) m_hold = k;
          m_key = k;
        end
      end else if (d > 0) begin
        m_diff = d;
        m_left = PC;
      end
    end
  end

  function automatic logic [2*NK+2:0] model_out();
    logic [NK-1:0] p;
    logic [NK-1:0] h;
    p = '0;
    h = '0;
    if (m_key >= 0) p[m_key] = 1'b1;
    if (m_hold >= 0) h[m_hold] = 1'b1;
    return {p, h, 2'(m_diff), (m_left > 0)};
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Strobe ir_vld for one cycle; returns at the first cycle after the strobe.
  task automatic press(logic [7:0] c);
    ir_code = c;
    ir_vld  = 1'b1;
    @(negedge sys_clk);
    ir_vld  = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step(3);
    sys_rst = 1'b0;
    step(100);
    checks++; if (key_pulse !== 7'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=%b", key_pulse, 7'b0); end
    checks++; if (key_hold !== 7'b0) begin failures++; $display("FAIL reset_hold got=%b exp=%b", key_hold, 7'b0); end
    checks++; if (diff !== 2'd1) begin failures++; $display("FAIL reset_diff got=%0d exp=1", diff); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_key_pulse();
    int bad;
    bad = 0;
    press(8'h42);
    checks++; if (key_pulse !== 7'b0010000) begin failures++; $display("FAIL pulse_first got=%b exp=%b", key_pulse, 7'b0010000); end
    for (int i = 1; i < PC; i++) begin
      step(1);
      if (key_pulse !== 7'b0010000) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL pulse_width bad_cycles=%0d exp=0", bad); end
    step(1);
    checks++; if (key_pulse !== 7'b0) begin failures++; $display("FAIL pulse_end got=%b exp=%b", key_pulse, 7'b0); end
    checks++; if (key_hold !== 7'b0) begin failures++; $display("FAIL pulse_hold got=%b exp=%b", key_hold, 7'b0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pulse_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_toggle();
    int bad;
    bad = 0;
    press(8'h46);
    checks++; if (key_hold !== 7'b0000001) begin failures++; $display("FAIL tog_on_hold got=%b exp=%b", key_hold, 7'b0000001); end
    checks++; if (key_pulse !== 7'b0000001) begin failures++; $display("FAIL tog_on_pulse got=%b exp=%b", key_pulse, 7'b0000001); end
    step(5999);
    press(8'h46);
    checks++; if (key_hold !== 7'b0) begin failures++; $display("FAIL tog_off_hold got=%b exp=%b", key_hold, 7'b0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tog_off_busy got=%b exp=1", busy); end
    for (int i = 0; i < PC; i++) begin
      if (key_pulse !== 7'b0) bad++;
      step(1);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL tog_off_nopulse bad_cycles=%0d exp=0", bad); end
    press(8'h46);
    step(PC);
    press(8'h15);
    checks++; if (key_hold !== 7'b0000010) begin failures++; $display("FAIL tog_switch_hold got=%b exp=%b", key_hold, 7'b0000010); end
    checks++; if (key_pulse !== 7'b0000010) begin failures++; $display("FAIL tog_switch_pulse got=%b exp=%b", key_pulse, 7'b0000010); end
    step(PC);
  endtask

  task automatic test_diff();
    int n;
    press(8'h19);
    checks++; if (diff !== 2'd2) begin failures++; $display("FAIL diff_load got=%0d exp=2", diff); end
    checks++; if (key_pulse !== 7'b0) begin failures++; $display("FAIL diff_nopulse got=%b exp=%b", key_pulse, 7'b0); end
    n = 0;
    while (busy === 1'b1 && n < PC + 10) begin n++; step(1); end
    checks++; if (n != PC) begin failures++; $display("FAIL diff_lock_len got=%0d exp=%0d", n, PC); end
    press(8'h42);
    step(99);
    press(8'h0d);
    checks++; if (diff !== 2'd2) begin failures++; $display("FAIL diff_drop got=%0d exp=2", diff); end
    n = 0;
    while (key_pulse !== 7'b0 && n < PC + 10) begin n++; step(1); end
    checks++; if (n != PC - 100) begin failures++; $display("FAIL drop_no_retrigger got=%0d exp=%0d", n, PC - 100); end
    checks++; if (diff !== 2'd2) begin failures++; $display("FAIL diff_after_drop got=%0d exp=2", diff); end
  endtask

  task automatic test_corner();
    press(8'hff);
    checks++; if ({busy, key_pulse} !== 8'b0) begin failures++; $display("FAIL unknown_code got=%b exp=%b", {busy, key_pulse}, 8'b0); end
    ir_code = 8'h4a; ir_vld = 1'b1; ir_rpt = 1'b1;
    step(1);
    ir_vld = 1'b0; ir_rpt = 1'b0;
    checks++; if (key_pulse !== 7'b0100000) begin failures++; $display("FAIL vld_wins got=%b exp=%b", key_pulse, 7'b0100000); end
    step(PC);
    press(8'h43);
    step(PC);
    press(8'h40);
    step(1999);
    checks++; if (key_pulse !== 7'b1000000) begin failures++; $display("FAIL pre_reset_pulse got=%b exp=%b", key_pulse, 7'b1000000); end
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    checks++; if (key_pulse !== 7'b0) begin failures++; $display("FAIL midreset_pulse got=%b exp=%b", key_pulse, 7'b0); end
    checks++; if (key_hold !== 7'b0) begin failures++; $display("FAIL midreset_hold got=%b exp=%b", key_hold, 7'b0); end
    checks++; if ({busy, diff} !== 3'b001) begin failures++; $display("FAIL midreset_busy_diff got=%b exp=%b", {busy, diff}, 3'b001); end
    step(10);
    checks++; if (key_pulse !== 7'b0) begin failures++; $display("FAIL midreset_no_resume got=%b exp=%b", key_pulse, 7'b0); end
  endtask

  task automatic test_repeat();
`ifdef IR_KEY_AUTO_REPEAT_EN
    logic [3:0] exp_p;
    logic       got;
    exp_p = 4'b1100;
    press(8'h42);
    step(PC);
    checks++; if ({busy, key_pulse} !== 8'b10000000) begin failures++; $display("FAIL hold_entry got=%b exp=%b", {busy, key_pulse}, 8'b10000000); end
    for (int r = 0; r < 4; r++) begin
      ir_rpt = 1'b1;
      step(1);
      ir_rpt = 1'b0;
      got = key_pulse[4];
      checks++; if (got !== exp_p[r]) begin failures++; $display("FAIL rpt_pulse_%0d got=%b exp=%b", r, got, exp_p[r]); end
      if (got === 1'b1) step(PC); else step(10);
    end
    step(RT - 10);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_before_timeout got=%b exp=1", busy); end
    step(20);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_timeout got=%b exp=0", busy); end
`else
    press(8'h42);
    step(PC);
    for (int r = 0; r < 4; r++) begin
      ir_rpt = 1'b1;
      step(1);
      ir_rpt = 1'b0;
      checks++; if ({busy, key_pulse} !== 8'b0) begin failures++; $display("FAIL rpt_ignored_%0d got=%b exp=%b", r, {busy, key_pulse}, 8'b0); end
      step(10);
    end
`endif
  endtask

  task automatic test_random();
    int  sel;
    bit  stop;
    stop = 1'b0;
    for (int t = 0; t < 12000 && !stop; t++) begin
      sel     = int'($urandom_range(0, 11));
      ir_vld  = ($urandom_range(0, 299) == 0);
      ir_rpt  = ($urandom_range(0, 49) == 0);
      if (sel < 7)       ir_code = key_tab[sel];
      else if (sel < 10) ir_code = diff_tab[sel - 7];
      else               ir_code = 8'($urandom_range(0, 255));
      step(1);
      checks++;
      if ({key_pulse, key_hold, diff, busy} !== model_out()) begin
        failures++;
        stop = 1'b1;
        $display("FAIL random_cycle_%0d got=%b exp=%b", t, {key_pulse, key_hold, diff, busy}, model_out());
      end
    end
    ir_vld = 1'b0;
    ir_rpt = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef IR_KEY_AUTO_REPEAT_EN
    test_repeat();
`else
    test_key_pulse();
    test_toggle();
    test_diff();
    test_corner();
    test_repeat();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
